// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: pipeline opcodes,
// arbiter FSM encodings and port-owner selector.
package dmem_port_arbiter_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  typedef enum logic {
    ARB_S   = 1'b0,
    FORCE_S = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PER  = 2'd2
  } owner_e;

  function automatic logic [4:0] insn_opcode(input logic [4:0] insn_hi);
    return insn_hi;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Peripheral-master bus into the data-memory arbiter: request/grant handshake
// plus one-cycle-delayed read return.
interface dmem_port_arbiter_if #(
  parameter int AW = 12
) ();
  logic          per_req;
  logic          per_we;
  logic [AW-1:0] per_addr;
  logic [31:0]   per_wdata;
  logic          per_gnt;
  logic          per_rvalid;
  logic [31:0]   per_rdata;

  modport master (
    output per_req, per_we, per_addr, per_wdata,
    input  per_gnt, per_rvalid, per_rdata
  );

  modport slave (
    input  per_req, per_we, per_addr, per_wdata,
    output per_gnt, per_rvalid, per_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port dmem arbiter: CPU XM stage has fixed priority, the peripheral is
// forced in (stalling the pipeline one cycle) after MAX_WAIT consecutive losses.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW       = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [31:0]   cpu_insn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  dmem_port_arbiter_if.slave per,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  localparam int              CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(MAX_WAIT);
  localparam logic [CW-1:0]   CNT_FORCE = CW'(MAX_WAIT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  owner_e        owner;
  logic [4:0]    opcode;
  logic          cpu_req, cpu_we;
  logic          unused_insn_bits;

  assign opcode           = insn_opcode(cpu_insn[31:27]);
  assign cpu_req          = (opcode == OP_SW) || (opcode == OP_LW);
  assign cpu_we           = (opcode == OP_SW);
  assign unused_insn_bits = ^cpu_insn[26:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_S;
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // Only a contended ARB cycle counts as a loss; any grant, an idle
  // peripheral, or the FORCE cycle itself clears the count.
  always_comb begin
    state_d    = ARB_S;
    wait_cnt_d = '0;
    case (state_q)
      ARB_S: begin
        if (cpu_req && per.per_req) begin
          wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CW'(1);
          if (wait_cnt_q == CNT_FORCE) state_d = FORCE_S;
        end
      end
      default: begin
        state_d    = ARB_S;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Reset gates ownership combinationally so nothing is issued while held.
  always_comb begin
    owner     = OWN_NONE;
    cpu_stall = 1'b0;
    if (reset_n) begin
      if (per.per_req && (state_q == FORCE_S || !cpu_req)) begin
        owner     = OWN_PER;
        cpu_stall = cpu_req;
      end else if (cpu_req) begin
        owner = OWN_CPU;
      end
    end

    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    case (owner)
      OWN_CPU: mem_we = cpu_we;
      OWN_PER: begin
        mem_addr  = per.per_addr;
        mem_wdata = per.per_wdata;
        mem_we    = per.per_we;
      end
      default: mem_we = 1'b0;
    endcase

    per.per_gnt = (owner == OWN_PER);
    rd_pend_d   = (owner == OWN_PER) && !per.per_we;
  end

  assign per.per_rvalid = rd_pend_q;
  assign per.per_rdata  = mem_rdata;
  assign cpu_rdata      = mem_rdata;

endmodule
